mem_stage: RTL and testbench

//  MIPS pipeline MEM stage, directly downstream of EX and its EX/MEM register.

---
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, wait-stated word load/store on a local data memory, MEM/WB register.
// Optional build macro DMEM_ALIGN_CHECK_EN adds misaligned-access suppression and the misalign port.
module mem_stage #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] EX_MEM_NPC,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  wb_ctlout,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
`ifdef DMEM_ALIGN_CHECK_EN
  , output logic      misalign
`endif
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned CNT_INIT = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
  localparam bit          HAS_WAIT = (MEM_LATENCY > 0);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_c;
  logic                  req_c, acc_c, misalign_c;
  logic                  stall_raw_c, complete_raw_c, complete_c;
  logic                  is_load_c, is_store_c;
  logic                  unused_c;

  assign idx_c      = alu_result[ADDR_WIDTH+1:2];
  assign req_c      = memread | memwrite;
  // A simultaneous read and write request is handled as a plain store.
  assign is_store_c = memwrite;
  assign is_load_c  = memread & ~memwrite;
  assign unused_c   = ^{alu_result[31:ADDR_WIDTH+2], alu_result[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_c = req_c & (alu_result[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif
  assign acc_c = req_c & ~misalign_c;

  assign pcsrc         = branch & zero;
  assign branch_target = EX_MEM_NPC;

  // Access sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: one IDLE stall cycle, then count down the remaining wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (acc_c && HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(CNT_INIT);
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs of the sequencer: stall while waiting, complete on the final cycle.
  always_comb begin
    stall_raw_c    = 1'b0;
    complete_raw_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_raw_c    = acc_c & HAS_WAIT;
        complete_raw_c = acc_c & ~HAS_WAIT;
      end
      S_WAIT: begin
        stall_raw_c    = (cnt_q != '0);
        complete_raw_c = (cnt_q == '0);
      end
      default: begin
        stall_raw_c    = 1'b0;
        complete_raw_c = 1'b0;
      end
    endcase
  end

  // Reset drops any pending access immediately.
  assign stall      = stall_raw_c & ~reset;
  assign complete_c = complete_raw_c & ~reset;

  // Data memory contents survive reset.
  always_ff @(posedge clk) begin
    if (complete_c && is_store_c) mem_q[idx_c] <= rdata2out;
  end

  // MEM/WB register; stalled or suppressed cycles insert a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ctlout      <= '0;
      read_data      <= '0;
      mem_alu_result <= '0;
      mem_write_reg  <= '0;
    end else if (stall_raw_c || misalign_c) begin
      wb_ctlout      <= '0;
    end else begin
      wb_ctlout      <= wb_ctl;
      mem_alu_result <= alu_result;
      mem_write_reg  <= five_bit_muxout;
      if (is_load_c) read_data <= mem_q[idx_c];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= misalign_c;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded random bench for mem_stage: one instance with two wait states, one single-cycle.
module tb_mem_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic        br;
    logic        rd;
    logic        wr;
    logic        z;
    logic [31:0] npc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rg;
  } txn_t;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    bit          rd_known;
    logic [31:0] alu;
    logic [4:0]  rg;
    bit          mis;
  } exp_t;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  txn_t in_a, in_b;
  logic        pcsrc_a, stall_a, pcsrc_b, stall_b;
  logic [31:0] bt_a, rdo_a, alu_a, bt_b, rdo_b, alu_b;
  logic [1:0]  wbo_a, wbo_b;
  logic [4:0]  reg_a, reg_b;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        mis_a, mis_b;
`endif

  mem_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .wb_ctl(in_a.wb), .branch(in_a.br), .memread(in_a.rd),
    .memwrite(in_a.wr), .zero(in_a.z), .EX_MEM_NPC(in_a.npc), .alu_result(in_a.alu),
    .rdata2out(in_a.wd), .five_bit_muxout(in_a.rg), .pcsrc(pcsrc_a), .branch_target(bt_a),
    .stall(stall_a), .wb_ctlout(wbo_a), .read_data(rdo_a), .mem_alu_result(alu_a),
    .mem_write_reg(reg_a)
`ifdef DMEM_ALIGN_CHECK_EN
    , .misalign(mis_a)
`endif
  );

  mem_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(0)) u_dut_b (
    .clk(clk), .reset(reset), .wb_ctl(in_b.wb), .branch(in_b.br), .memread(in_b.rd),
    .memwrite(in_b.wr), .zero(in_b.z), .EX_MEM_NPC(in_b.npc), .alu_result(in_b.alu),
    .rdata2out(in_b.wd), .five_bit_muxout(in_b.rg), .pcsrc(pcsrc_b), .branch_target(bt_b),
    .stall(stall_b), .wb_ctlout(wbo_b), .read_data(rdo_b), .mem_alu_result(alu_b),
    .mem_write_reg(reg_b)
`ifdef DMEM_ALIGN_CHECK_EN
    , .misalign(mis_b)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word memory per instance plus the architectural MEM/WB contents.
  logic [31:0] ref_mem [int];
  logic [31:0] m_rd    [2];
  bit          m_known [2];
  logic [31:0] m_alu   [2];
  logic [4:0]  m_rg    [2];
  exp_t q_a[$];
  exp_t q_b[$];
  bit armed_a = 0, armed_b = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_rd[s] = '0; m_known[s] = 1; m_alu[s] = '0; m_rg[s] = '0;
    end
  endfunction

  function automatic exp_t model_step(input int sel, input txn_t t);
    exp_t e;
    int key;
    bit mis;
    key = sel * 4096 + int'((t.alu / 4) % 256);
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (t.rd || t.wr) && (t.alu % 4 != 0);
`else
    mis = 0;
`endif
    if (mis) begin
      e.wb = 2'b00;
    end else begin
      if (t.wr) ref_mem[key] = t.wd;
      else if (t.rd) begin
        m_known[sel] = ref_mem.exists(key);
        if (m_known[sel]) m_rd[sel] = ref_mem[key];
      end
      m_alu[sel] = t.alu;
      m_rg[sel]  = t.rg;
      e.wb = t.wb;
    end
    e.rd = m_rd[sel]; e.rd_known = m_known[sel];
    e.alu = m_alu[sel]; e.rg = m_rg[sel]; e.mis = mis;
    return e;
  endfunction

  function automatic txn_t mk(input logic [1:0] wb, input logic rd, input logic wr,
                              input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rg);
    txn_t t;
    t = '0;
    t.wb = wb; t.rd = rd; t.wr = wr; t.alu = alu; t.wd = wd; t.rg = rg;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int kind;
    kind = int'($urandom_range(0, 3));
    t.wb  = 2'($urandom);
    t.br  = 1'($urandom);
    t.z   = 1'($urandom);
    t.rd  = (kind == 1) || (kind == 3);
    t.wr  = (kind == 2) || (kind == 3);
    t.npc = $urandom;
    t.alu = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) * 4);
    t.wd  = $urandom;
    t.rg  = 5'($urandom);
    return t;
  endfunction

  function automatic logic stall_of(input int sel);
    return (sel == 0) ? stall_a : stall_b;
  endfunction

  // Drive one EX/MEM transaction, hold it through the stall, queue the expected MEM/WB result.
  task automatic issue(input int sel, input txn_t t);
    exp_t e;
    int waits;
    int exp_stall;
    waits = 0;
    @(posedge clk); #1;
    if (sel == 0) begin in_a = t; armed_a = 1; end
    else          begin in_b = t; armed_b = 1; end
    e = model_step(sel, t);
    exp_stall = ((t.rd || t.wr) && !e.mis && sel == 0) ? LAT_A : 0;
    @(negedge clk);
    if (sel == 0) begin
      check32("pcsrc", 32'(pcsrc_a), 32'(t.br & t.z));
      check32("branch_target", bt_a, t.npc);
    end
    while (stall_of(sel) && waits < 10) begin
      waits++;
      @(negedge clk);
    end
    check32(sel == 0 ? "stall_cycles_a" : "stall_cycles_b", 32'(waits), 32'(exp_stall));
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic cmp_entry(input string tag, input exp_t e, input logic [1:0] wb,
                           input logic [31:0] rd, input logic [31:0] al, input logic [4:0] rg);
    check32({tag, "_wb_ctlout"}, 32'(wb), 32'(e.wb));
    if (e.rd_known) check32({tag, "_read_data"}, rd, e.rd);
    check32({tag, "_mem_alu_result"}, al, e.alu);
    check32({tag, "_mem_write_reg"}, 32'(rg), 32'(e.rg));
  endtask

  // Monitors: prev 1 = last edge was a completion (pop and compare), 2 = stall (expect bubble).
  int prev_a = 0, prev_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) prev_a = 0;
    else begin
      if (prev_a == 1) begin
        if (q_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_scoreboard: output with no expected entry at %0t", $time);
        end else begin
          e = q_a.pop_front();
          cmp_entry("a", e, wbo_a, rdo_a, alu_a, reg_a);
`ifdef DMEM_ALIGN_CHECK_EN
          check32("a_misalign", 32'(mis_a), 32'(e.mis));
`endif
        end
      end else if (prev_a == 2) check32("a_bubble_wb_ctlout", 32'(wbo_a), 32'd0);
      prev_a = !armed_a ? 0 : (stall_a ? 2 : 1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) prev_b = 0;
    else begin
      if (prev_b == 1) begin
        if (q_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_scoreboard: output with no expected entry at %0t", $time);
        end else begin
          e = q_b.pop_front();
          cmp_entry("b", e, wbo_b, rdo_b, alu_b, reg_b);
`ifdef DMEM_ALIGN_CHECK_EN
          check32("b_misalign", 32'(mis_b), 32'(e.mis));
`endif
        end
      end else if (prev_b == 2) check32("b_bubble_wb_ctlout", 32'(wbo_b), 32'd0);
      prev_b = !armed_b ? 0 : (stall_b ? 2 : 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    reset = 1'b1;
    in_a = '0;
    in_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("rst_wb_ctlout", 32'(wbo_a), 32'd0);
    check32("rst_read_data", rdo_a, 32'd0);
    check32("rst_mem_alu_result", alu_a, 32'd0);
    check32("rst_mem_write_reg", 32'(reg_a), 32'd0);
    check32("rst_stall", 32'(stall_a), 32'd0);
    check32("rst_b_wb_ctlout", 32'(wbo_b), 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    check32("rst_misalign", 32'(mis_a), 32'd0);
`endif
    @(negedge clk); #1;
    reset = 1'b0;

    // Prefill the low 16 words so later random loads have defined data.
    for (int i = 0; i < 16; i++) issue(0, mk(2'b00, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0));

    issue(0, mk(2'b10, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9));
    t = mk(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    t.br = 1'b1; t.z = 1'b1; t.npc = 32'h40;
    issue(0, t);
    t.z = 1'b0;
    issue(0, t);
    issue(0, mk(2'b00, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 5'd0));
    issue(0, mk(2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 5'd7));
    issue(0, mk(2'b11, 1'b1, 1'b0, 32'h22, 32'h0, 5'd3));

    repeat (60) issue(0, rand_txn());

    // Reset in the middle of a store's wait sequence.
    @(posedge clk); #1;
    in_a = mk(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0);
    @(posedge clk); #1;
    check32("pre_reset_stall", 32'(stall_a), 32'd1);
    armed_a = 0;
    reset = 1'b1;
    #1;
    check32("mid_reset_stall", 32'(stall_a), 32'd0);
    check32("mid_reset_wb_ctlout", 32'(wbo_a), 32'd0);
    check32("mid_reset_read_data", rdo_a, 32'd0);
    check32("mid_reset_mem_alu_result", alu_a, 32'd0);
    in_a = '0;
    @(negedge clk); #1;
    reset = 1'b0;
    model_reset();
    q_a.delete();
    issue(0, mk(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4));

    issue(0, mk(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0));
    @(posedge clk); #1;
    armed_a = 0;

    // Single-cycle instance: alternating store/load, then random traffic.
    for (int i = 0; i < 8; i++) begin
      issue(1, mk(2'b00, 1'b0, 1'b1, 32'h04, $urandom, 5'd0));
      issue(1, mk(2'b11, 1'b1, 1'b0, 32'h04, 32'h0, 5'(i)));
    end
    repeat (20) issue(1, rand_txn());
    issue(1, mk(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0));
    @(posedge clk); #1;
    armed_b = 0;

    repeat (3) @(negedge clk);
    check32("a_drain", 32'(q_a.size()), 32'd0);
    check32("b_drain", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
